// File: rtl/vid_pkg.sv
// Shared types and constants for the vid_io position-tracking front end.
// The 1080p active sizes are also used for colour_change row-buffer sizing.
package vid_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    HBLANK = 2'd3
  } vid_pos_state_t;

  localparam int VID_DATA_WIDTH = 24;
  localparam int VID_X_WIDTH    = 12;
  localparam int VID_Y_WIDTH    = 11;

  localparam int VID_H_ACTIVE = 1920;
  localparam int VID_V_ACTIVE = 1080;

endpackage

// File: rtl/vid_frame_measure.sv
// vid_frame_measure: captures active width/height per frame and tracks lock / format changes.
// Only compiled when VID_POS_MEASURE_EN is defined (instantiated by vid_position_tracker).
`ifdef VID_POS_MEASURE_EN
module vid_frame_measure
  import vid_pkg::*;
#(
  parameter int X_WIDTH = VID_X_WIDTH,
  parameter int Y_WIDTH = VID_Y_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_line_end,
  input  logic               i_frame_end,
  input  logic               i_abort,
  input  logic               i_fmt_err,
  input  logic [X_WIDTH-1:0] i_x,
  input  logic [Y_WIDTH-1:0] i_y,
  output logic [X_WIDTH-1:0] o_width,
  output logic [Y_WIDTH-1:0] o_height,
  output logic               o_locked,
  output logic               o_fmt_change
);
  localparam logic [X_WIDTH-1:0] X_MAX = '1;
  localparam logic [Y_WIDTH-1:0] Y_MAX = '1;

  logic [X_WIDTH-1:0] r_ref_w, r_width, w_line_w;
  logic [Y_WIDTH-1:0] r_height, w_frame_h;
  logic               r_mismatch, r_err, r_prev_good, r_have_prev;
  logic               r_locked, r_fmt_change;
  logic               w_bad, w_same;

  // i_x / i_y are the last pixel's coordinates, so counts are one more (clamped).
  assign w_line_w  = (i_x == X_MAX) ? X_MAX : i_x + X_WIDTH'(1);
  assign w_frame_h = (i_y == Y_MAX) ? Y_MAX : i_y + Y_WIDTH'(1);
  assign w_bad     = r_mismatch | r_err;
  assign w_same    = (r_ref_w == r_width) && (w_frame_h == r_height);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_w      <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_mismatch   <= 1'b0;
      r_err        <= 1'b0;
      r_prev_good  <= 1'b0;
      r_have_prev  <= 1'b0;
      r_locked     <= 1'b0;
      r_fmt_change <= 1'b0;
    end else begin
      r_fmt_change <= 1'b0;
      if (i_fmt_err)
        r_err <= 1'b1;
      if (i_line_end) begin
        if (i_y == '0)
          r_ref_w <= w_line_w;
        else if (w_line_w != r_ref_w)
          r_mismatch <= 1'b1;
      end
      if (i_abort) begin
        r_locked     <= 1'b0;
        r_fmt_change <= 1'b1;
        r_prev_good  <= 1'b0;
        r_mismatch   <= 1'b0;
        r_err        <= 1'b0;
      end else if (i_frame_end) begin
        r_width      <= r_ref_w;
        r_height     <= w_frame_h;
        r_fmt_change <= w_bad | (r_have_prev & ~w_same);
        r_locked     <= ~w_bad & r_prev_good & w_same;
        r_prev_good  <= ~w_bad;
        r_have_prev  <= 1'b1;
        r_mismatch   <= 1'b0;
        r_err        <= 1'b0;
      end
    end
  end

  assign o_width      = r_width;
  assign o_height     = r_height;
  assign o_locked     = r_locked;
  assign o_fmt_change = r_fmt_change;

endmodule
`endif

// File: rtl/vid_position_tracker.sv
// vid_position_tracker: re-registers the vid_io stream and tags each pixel with x/y and SOL/EOL/SOF.
// Define VID_POS_MEASURE_EN to add per-frame width/height measurement, lock and format-change reporting.
module vid_position_tracker
  import vid_pkg::*;
#(
  parameter int   DATA_WIDTH   = VID_DATA_WIDTH,
  parameter int   X_WIDTH      = VID_X_WIDTH,
  parameter int   Y_WIDTH      = VID_Y_WIDTH,
  parameter logic VSYNC_ACTIVE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_vid_data,
  input  logic                  i_vid_hsync,
  input  logic                  i_vid_vsync,
  input  logic                  i_vid_VDE,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  output logic [X_WIDTH-1:0]    o_x,
  output logic [Y_WIDTH-1:0]    o_y,
  output logic                  o_sol,
  output logic                  o_eol,
  output logic                  o_sof,
  output logic                  o_locked,
  output logic [X_WIDTH-1:0]    o_width,
  output logic [Y_WIDTH-1:0]    o_height,
  output logic                  o_fmt_change
);
  localparam logic [X_WIDTH-1:0] X_MAX = '1;
  localparam logic [Y_WIDTH-1:0] Y_MAX = '1;

  vid_pos_state_t        r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_hsync, r_vsync, r_vde;
  logic [X_WIDTH-1:0]    r_x, w_x_next;
  logic [Y_WIDTH-1:0]    r_y, w_y_next;
  logic                  r_sol, r_eol, r_sof;
  logic                  w_sol_next, w_eol_next, w_sof_next;
  logic                  w_vs_edge, w_vde_rise;

  // r_vsync / r_vde double as the previous-cycle copies for edge detection.
  assign w_vs_edge  = (i_vid_vsync == VSYNC_ACTIVE) && (r_vsync != VSYNC_ACTIVE);
  assign w_vde_rise = i_vid_VDE && !r_vde;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEEK;
      r_data  <= '0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_vde   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_sol   <= 1'b0;
      r_eol   <= 1'b0;
      r_sof   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= i_vid_data;
      r_hsync <= i_vid_hsync;
      r_vsync <= i_vid_vsync;
      r_vde   <= i_vid_VDE;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_sol   <= w_sol_next;
      r_eol   <= w_eol_next;
      r_sof   <= w_sof_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_sol_next   = 1'b0;
    w_eol_next   = 1'b0;
    w_sof_next   = 1'b0;
    case (r_state)
      SEEK: begin
        if (w_vs_edge)
          w_state_next = VBLANK;
      end
      ACTIVE: begin
        if (w_vs_edge) begin
          w_state_next = VBLANK;
        end else if (!i_vid_VDE) begin
          w_state_next = HBLANK;
          w_eol_next   = 1'b1;
        end else if (r_x != X_MAX) begin
          w_x_next = r_x + X_WIDTH'(1);
        end
      end
      default: begin
        // VBLANK / HBLANK: a vsync edge coinciding with a rise closes the frame and opens (0,0).
        if (w_vde_rise) begin
          w_state_next = ACTIVE;
          w_x_next     = '0;
          w_sol_next   = 1'b1;
          if (r_state == VBLANK || w_vs_edge) begin
            w_y_next   = '0;
            w_sof_next = 1'b1;
          end else if (r_y != Y_MAX) begin
            w_y_next = r_y + Y_WIDTH'(1);
          end
        end else if (w_vs_edge) begin
          w_state_next = VBLANK;
        end
      end
    endcase
  end

  assign o_vid_data  = r_data;
  assign o_vid_hsync = r_hsync;
  assign o_vid_vsync = r_vsync;
  assign o_vid_VDE   = r_vde;
  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_sol       = r_sol;
  assign o_eol       = r_eol;
  assign o_sof       = r_sof;

`ifdef VID_POS_MEASURE_EN
  logic w_line_end, w_frame_end, w_abort, w_fmt_err;

  assign w_line_end  = (r_state == ACTIVE) && !w_vs_edge && !i_vid_VDE;
  assign w_frame_end = (r_state == HBLANK) && w_vs_edge;
  assign w_abort     = (r_state == ACTIVE) && w_vs_edge;
  assign w_fmt_err   = ((r_state == ACTIVE) && !w_vs_edge && i_vid_VDE && (r_x == X_MAX)) ||
                       ((r_state == HBLANK) && !w_vs_edge && w_vde_rise && (r_y == Y_MAX));

  vid_frame_measure #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_measure (
    .clk          (clk),
    .rst          (rst),
    .i_line_end   (w_line_end),
    .i_frame_end  (w_frame_end),
    .i_abort      (w_abort),
    .i_fmt_err    (w_fmt_err),
    .i_x          (r_x),
    .i_y          (r_y),
    .o_width      (o_width),
    .o_height     (o_height),
    .o_locked     (o_locked),
    .o_fmt_change (o_fmt_change)
  );
`else
  logic r_locked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_locked <= 1'b0;
    else if (w_vs_edge)
      r_locked <= 1'b1;
  end

  assign o_locked     = r_locked;
  assign o_width      = '0;
  assign o_height     = '0;
  assign o_fmt_change = 1'b0;
`endif

endmodule

// File: tb/tb_vid_position_tracker.sv
// Directed bench for vid_position_tracker: table of frames plus hand-written corner sequences.
// Expectations for width/height/lock follow VID_POS_MEASURE_EN when the bench is built with it.
module tb_vid_position_tracker;

`ifdef VID_POS_MEASURE_EN
  localparam int MEAS = 1;
`else
  localparam int MEAS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] i_vid_data;
  logic        i_vid_hsync, i_vid_vsync, i_vid_VDE;

  logic [23:0] o_vid_data;
  logic        o_vid_hsync, o_vid_vsync, o_vid_VDE;
  logic [11:0] o_x, o_width;
  logic [10:0] o_y, o_height;
  logic        o_sol, o_eol, o_sof, o_locked, o_fmt_change;

  logic [23:0] s_vid_data;
  logic        s_vid_hsync, s_vid_vsync, s_vid_VDE;
  logic [2:0]  s_x, s_width;
  logic [10:0] s_y, s_height;
  logic        s_sol, s_eol, s_sof, s_locked, s_fmt_change;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int lines;
    int len;
    int short_idx;
    int short_len;
    int exp_w;
    int exp_h;
    int exp_locked;
    int exp_fmt;
  } frame_vec_t;

  frame_vec_t vecs [5];

  always #5 clk = ~clk;

  vid_position_tracker u_dut (
    .clk (clk), .rst (rst),
    .i_vid_data (i_vid_data), .i_vid_hsync (i_vid_hsync),
    .i_vid_vsync (i_vid_vsync), .i_vid_VDE (i_vid_VDE),
    .o_vid_data (o_vid_data), .o_vid_hsync (o_vid_hsync),
    .o_vid_vsync (o_vid_vsync), .o_vid_VDE (o_vid_VDE),
    .o_x (o_x), .o_y (o_y), .o_sol (o_sol), .o_eol (o_eol), .o_sof (o_sof),
    .o_locked (o_locked), .o_width (o_width), .o_height (o_height),
    .o_fmt_change (o_fmt_change)
  );

  vid_position_tracker #(.X_WIDTH(3)) u_small (
    .clk (clk), .rst (rst),
    .i_vid_data (i_vid_data), .i_vid_hsync (i_vid_hsync),
    .i_vid_vsync (i_vid_vsync), .i_vid_VDE (i_vid_VDE),
    .o_vid_data (s_vid_data), .o_vid_hsync (s_vid_hsync),
    .o_vid_vsync (s_vid_vsync), .o_vid_VDE (s_vid_VDE),
    .o_x (s_x), .o_y (s_y), .o_sol (s_sol), .o_eol (s_eol), .o_sof (s_sof),
    .o_locked (s_locked), .o_width (s_width), .o_height (s_height),
    .o_fmt_change (s_fmt_change)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic vde, input logic vs, input logic [23:0] d);
    i_vid_VDE   = vde;
    i_vid_vsync = vs;
    i_vid_hsync = !vde;
    i_vid_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic vs_tail();
    step(1'b0, 1'b1, 24'h0);
    step(1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_lines(input int lines, input int len, input int short_idx, input int short_len);
    for (int ln = 0; ln < lines; ln++) begin
      int n;
      n = (ln == short_idx) ? short_len : len;
      for (int p = 0; p < n; p++) begin
        logic [23:0] d;
        d = 24'(ln * 4096 + p) ^ 24'h5A5A5A;
        step(1'b1, 1'b0, d);
        chk("x", int'(o_x), p);
        chk("y", int'(o_y), ln);
        chk("sol", int'(o_sol), (p == 0) ? 1 : 0);
        chk("sof", int'(o_sof), (p == 0 && ln == 0) ? 1 : 0);
        chk("eol_active", int'(o_eol), 0);
        chk("data", int'(o_vid_data), int'(d));
        chk("x_sat", int'(s_x), (p > 7) ? 7 : p);
      end
      for (int b = 0; b < 4; b++) begin
        step(1'b0, 1'b0, 24'h0);
        chk("eol", int'(o_eol), (b == 0) ? 1 : 0);
        chk("x_hold", int'(o_x), n - 1);
        chk("hsync", int'(o_vid_hsync), 1);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 8, -1, 0, 8, 4, 0, 0};
    vecs[1] = '{4, 8, -1, 0, 8, 4, 1, 0};
    vecs[2] = '{4, 8,  2, 7, 8, 4, 0, 1};
    vecs[3] = '{4, 8, -1, 0, 8, 4, 0, 0};
    vecs[4] = '{4, 8, -1, 0, 8, 4, 1, 0};

    rst = 1'b1;
    i_vid_data = '0; i_vid_hsync = 1'b0; i_vid_vsync = 1'b0; i_vid_VDE = 1'b0;
    repeat (3) step(1'b0, 1'b0, 24'h0);
    chk("rst_x", int'(o_x), 0);
    chk("rst_y", int'(o_y), 0);
    chk("rst_sol", int'(o_sol), 0);
    chk("rst_sof", int'(o_sof), 0);
    chk("rst_locked", int'(o_locked), 0);
    chk("rst_width", int'(o_width), 0);
    chk("rst_fmt", int'(o_fmt_change), 0);
    rst = 1'b0;

    // Rising VDE before any vsync must not start a frame
    step(1'b1, 1'b0, 24'h1);
    chk("seek_sol", int'(o_sol), 0);
    chk("seek_sof", int'(o_sof), 0);
    step(1'b0, 1'b0, 24'h0);
    chk("locked_pre", int'(o_locked), 0);
    step(1'b0, 1'b1, 24'h0);
    chk("locked_vs", int'(o_locked), (MEAS != 0) ? 0 : 1);
    vs_tail();

    for (int i = 0; i < 5; i++) begin
      send_lines(vecs[i].lines, vecs[i].len, vecs[i].short_idx, vecs[i].short_len);
      step(1'b0, 1'b1, 24'h0);
      chk("frame_width", int'(o_width), (MEAS != 0) ? vecs[i].exp_w : 0);
      chk("frame_height", int'(o_height), (MEAS != 0) ? vecs[i].exp_h : 0);
      chk("frame_locked", int'(o_locked), (MEAS != 0) ? vecs[i].exp_locked : 1);
      chk("frame_fmt", int'(o_fmt_change), (MEAS != 0) ? vecs[i].exp_fmt : 0);
      chk("vsync_pass", int'(o_vid_vsync), 1);
      step(1'b0, 1'b1, 24'h0);
      chk("fmt_pulse_end", int'(o_fmt_change), 0);
      step(1'b0, 1'b0, 24'h0);
      step(1'b0, 1'b0, 24'h0);
    end

    // Truncated frame: vsync edge while o_x = 3
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 1'b0, 24'(p));
      chk("trunc_pre_x", int'(o_x), p);
    end
    step(1'b1, 1'b1, 24'h4);
    chk("trunc_x", int'(o_x), 3);
    chk("trunc_sol", int'(o_sol), 0);
    chk("trunc_eol", int'(o_eol), 0);
    chk("trunc_locked", int'(o_locked), (MEAS != 0) ? 0 : 1);
    chk("trunc_fmt", int'(o_fmt_change), MEAS);
    step(1'b0, 1'b1, 24'h0);
    chk("trunc_fmt_end", int'(o_fmt_change), 0);
    step(1'b0, 1'b0, 24'h0);
    send_lines(2, 5, -1, 0);

    // Vsync edge and VDE rise together in HBLANK: frame closes, pixel is (0,0)
    step(1'b1, 1'b1, 24'h77);
    chk("sim_sof", int'(o_sof), 1);
    chk("sim_sol", int'(o_sol), 1);
    chk("sim_x", int'(o_x), 0);
    chk("sim_y", int'(o_y), 0);
    chk("sim_width", int'(o_width), (MEAS != 0) ? 5 : 0);
    chk("sim_height", int'(o_height), (MEAS != 0) ? 2 : 0);
    chk("sim_fmt", int'(o_fmt_change), MEAS);
    chk("sim_locked", int'(o_locked), (MEAS != 0) ? 0 : 1);
    for (int p = 1; p < 5; p++) begin
      step(1'b1, 1'b1, 24'(p));
      chk("sim_x_run", int'(o_x), p);
      chk("sim_sof_once", int'(o_sof), 0);
    end
    step(1'b0, 1'b0, 24'h0);
    chk("sim_eol", int'(o_eol), 1);
    step(1'b0, 1'b0, 24'h0);

    // Reset asserted during line 2
    step(1'b0, 1'b1, 24'h0);
    vs_tail();
    send_lines(2, 8, -1, 0);
    for (int p = 0; p < 3; p++)
      step(1'b1, 1'b0, 24'(p + 16));
    rst = 1'b1;
    step(1'b1, 1'b0, 24'h13);
    chk("mid_rst_x", int'(o_x), 0);
    chk("mid_rst_y", int'(o_y), 0);
    chk("mid_rst_sol", int'(o_sol), 0);
    chk("mid_rst_eol", int'(o_eol), 0);
    chk("mid_rst_sof", int'(o_sof), 0);
    chk("mid_rst_locked", int'(o_locked), 0);
    chk("mid_rst_width", int'(o_width), 0);
    chk("mid_rst_height", int'(o_height), 0);
    chk("mid_rst_vde", int'(o_vid_VDE), 0);
    chk("mid_rst_data", int'(o_vid_data), 0);
    rst = 1'b0;
    for (int ln = 0; ln < 2; ln++) begin
      for (int p = 0; p < 8; p++) begin
        step(1'b1, 1'b0, 24'(p));
        chk("post_rst_sol", int'(o_sol), 0);
        chk("post_rst_sof", int'(o_sof), 0);
        chk("post_rst_x", int'(o_x), 0);
        chk("post_rst_y", int'(o_y), 0);
      end
      for (int b = 0; b < 4; b++) begin
        step(1'b0, 1'b0, 24'h0);
        chk("post_rst_eol", int'(o_eol), 0);
      end
    end

    // 10-pixel lines into the 3-bit column counter
    step(1'b0, 1'b1, 24'h0);
    chk("sat_locked_vs", int'(s_locked), (MEAS != 0) ? 0 : 1);
    vs_tail();
    send_lines(2, 10, -1, 0);
    step(1'b0, 1'b1, 24'h0);
    chk("sat_fmt", int'(s_fmt_change), MEAS);
    chk("sat_locked", int'(s_locked), (MEAS != 0) ? 0 : 1);
    chk("sat_main_fmt", int'(o_fmt_change), 0);
    chk("sat_main_width", int'(o_width), (MEAS != 0) ? 10 : 0);
    chk("sat_main_height", int'(o_height), (MEAS != 0) ? 2 : 0);
    step(1'b0, 1'b1, 24'h0);
    chk("sat_fmt_end", int'(s_fmt_change), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vid_position_tracker.md
# vid_position_tracker

Upstream stage that sits directly in front of the `colour_change` colour/kernel stage on the vid_io pixel path. It re-registers the pixel stream and derives true active-pixel coordinates and line/frame strobes from `VDE`/`vsync`, replacing free-running counters. It optionally measures active width and height per frame and reports lock and format changes. Downstream stages use `o_x`/`o_y` for windowing, row-buffer addressing and sprite placement.

## Interface

Parameters:
- `DATA_WIDTH`, 24: pixel width, 8 bits each for R, B, G.
- `X_WIDTH`, 12: column counter width.
- `Y_WIDTH`, 11: row counter width.
- `VSYNC_ACTIVE`, 1: asserted level of `i_vid_vsync`.

Ports:
- `clk`, in, 1: pixel clock; single clock domain.
- `rst`, in, 1: reset, asynchronous, active-high.
- `i_vid_data`, in, `DATA_WIDTH`: pixel data.
- `i_vid_hsync`, in, 1: horizontal sync, passed through.
- `i_vid_vsync`, in, 1: vertical sync.
- `i_vid_VDE`, in, 1: active video enable.
- `o_vid_data`, `o_vid_hsync`, `o_vid_vsync`, `o_vid_VDE`, out, as inputs: the input stream delayed by 1 cycle.
- `o_x`, out, `X_WIDTH`: column of the current output pixel.
- `o_y`, out, `Y_WIDTH`: row of the current output pixel.
- `o_sol`, out, 1: 1-cycle pulse on the first active pixel of a line.
- `o_eol`, out, 1: 1-cycle pulse on the last active pixel of a line.
- `o_sof`, out, 1: 1-cycle pulse on pixel (0,0) of a frame.
- `o_locked`, out, 1: frame geometry is stable.
- `o_width`, out, `X_WIDTH`: active pixels per line from the last complete frame.
- `o_height`, out, `Y_WIDTH`: active lines from the last complete frame.
- `o_fmt_change`, out, 1: 1-cycle pulse when the geometry differs from the previous frame.

## Operation

- Vsync leading edge (`vs_edge`): `i_vid_vsync` goes to `VSYNC_ACTIVE` this cycle and was not at that level the previous cycle.
- VDE edges come from a 1-cycle registered copy of `i_vid_VDE`.
- State machine:
  - `SEEK`: the reset state. Coordinates held at 0; no strobes. On `vs_edge`, go to `VBLANK`.
  - `VBLANK`: on a VDE rise, go to `ACTIVE` with x=0, y=0, and assert `o_sof` and `o_sol`.
  - `ACTIVE`: x increments on each VDE-high cycle. On a VDE fall, go to `HBLANK`; `o_eol` is asserted on the last VDE-high pixel, one cycle after that pixel.
  - `HBLANK`: on a VDE rise, go to `ACTIVE` with x=0, y+1, and assert `o_sol`. On `vs_edge`, go to `VBLANK`; the frame is complete.
- Simultaneous `vs_edge` and VDE rise in `HBLANK` or `VBLANK`: the frame ends first, then the pixel is (0,0) with `o_sof` asserted.
- `vs_edge` while in `ACTIVE`: the frame is truncated. Go to `VBLANK`. With measurement enabled, `o_locked` clears and `o_fmt_change` pulses.
- Counter limits: x saturates at 2^`X_WIDTH`−1 and y saturates at 2^`Y_WIDTH`−1; neither wraps. Saturation counts as a format error: with measurement enabled, `o_locked` clears and `o_fmt_change` pulses.
- Outside active video, `o_x`/`o_y` hold their last values.

## Timing

- Latency is exactly 1 cycle for every output relative to the inputs. All outputs are registered.
- Reset values: all outputs 0; state is `SEEK`.
- Reset asserted mid-frame: immediate return to `SEEK`. No strobes until the next `vs_edge`, followed by a VDE rise.
- `o_width`/`o_height` update on the cycle after the frame-ending `vs_edge`.

## Configuration

- Macro: `VID_POS_MEASURE_EN`.
- When defined:
  - The width of line 0 is the reference width. Any later line of a different length marks the frame as mismatched.
  - At frame end, `o_width`/`o_height` are loaded from the frame.
  - `o_locked` sets after two consecutive complete, unmismatched frames with identical width and height.
  - Any difference clears `o_locked` and pulses `o_fmt_change` in the same cycle as the `o_width`/`o_height` update.
- When undefined:
  - `o_width`/`o_height` are tied to 0 and `o_fmt_change` is tied to 0.
  - `o_locked` sets on the first `vs_edge` after reset and stays set.

## Structure

- Package `vid_pkg` holds:
  - the state enum `vid_pos_state_t` (`SEEK`, `VBLANK`, `ACTIVE`, `HBLANK`);
  - the default widths;
  - the 1080p constants `VID_H_ACTIVE`=1920 and `VID_V_ACTIVE`=1080, shared with `colour_change` row-buffer sizing.
- One sub-module, `vid_frame_measure`:
  - inputs: line-end, frame-end and x/y;
  - outputs: width, height, locked and fmt_change;
  - instantiated only under `VID_POS_MEASURE_EN`.

## Test plan

- Reset, then a 4-line frame of 8 active pixels per line with 4 blank cycles between lines, preceded by vsync:
  - `o_sof` asserts once, on `o_x`=0, `o_y`=0;
  - `o_eol` asserts on `o_x`=7 of each line;
  - the last pixel is (7,3).
- Two identical 8×4 frames (measurement enabled): after the second frame end, `o_width`=8, `o_height`=4 and `o_locked`=1.
- Third frame with one line of 7 pixels: `o_fmt_change` pulses once at frame end and `o_locked`=0.
- Vsync edge injected at `o_x`=3 mid-line: state goes to `VBLANK`, `o_locked`=0, and the next VDE rise gives (0,0) with `o_sof`.
- `rst` pulsed during line 2: all outputs read 0 next cycle. Traffic before the next vsync produces no `o_sol`/`o_sof`.
- `X_WIDTH`=3 with a 10-pixel line: `o_x` holds at 7 for the last 3 pixels, and `o_fmt_change` pulses at frame end.
